// File: rtl/clint_regif.sv
`default_nettype none
// ============================================================================
// Module   : clint_regif
// Purpose  : Bus register front end for the CLINT: decodes single 32-bit
//            accesses into MSIP/MTIMECMP write strobes and serves reads from
//            shadow copies, with a coherent two-access 64-bit MTIME read.
// Revision : 1.0 - initial release
// ============================================================================
module clint_regif #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        be_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              msip_we_o,
    output logic              msip_wdata_o,
    output logic              mtimecmp_we_o,
    output logic [63:0]       mtimecmp_wdata_o,
    input  logic [63:0]       mtime_i
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_resp = 1'b1;

    localparam logic [ADDR_W-1:0] c_off_msip     = ADDR_W'(32'h0000);
    localparam logic [ADDR_W-1:0] c_off_mtcmp_lo = ADDR_W'(32'h4000);
    localparam logic [ADDR_W-1:0] c_off_mtcmp_hi = ADDR_W'(32'h4004);
    localparam logic [ADDR_W-1:0] c_off_mtime_lo = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] c_off_mtime_hi = ADDR_W'(32'hBFFC);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        r_msip;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_snap_hi;
    logic        r_snap_v;

    logic        w_accept;
    logic        w_hit_msip, w_hit_lo, w_hit_hi, w_hit_mtlo, w_hit_mthi;
    logic        w_err;
    logic        w_ok_rd, w_ok_wr;
    logic        w_msip_wr, w_mtc_wr;
    logic [31:0] w_half_old, w_half_new;
    logic [63:0] w_mtc_merged;
    logic [31:0] w_rdata;

    // Address decode and error classification
    assign w_hit_msip = (addr_i == c_off_msip);
    assign w_hit_lo   = (addr_i == c_off_mtcmp_lo);
    assign w_hit_hi   = (addr_i == c_off_mtcmp_hi);
    assign w_hit_mtlo = (addr_i == c_off_mtime_lo);
    assign w_hit_mthi = (addr_i == c_off_mtime_hi);

    assign w_err = (addr_i[1:0] != 2'b00)
                 | ~(w_hit_msip | w_hit_lo | w_hit_hi | w_hit_mtlo | w_hit_mthi)
                 | (we_i & (w_hit_mtlo | w_hit_mthi));

    assign w_ok_rd   = w_accept & ~w_err & ~we_i;
    assign w_ok_wr   = w_accept & ~w_err & we_i;
    assign w_msip_wr = w_ok_wr & w_hit_msip & be_i[0];
    assign w_mtc_wr  = w_ok_wr & (w_hit_lo | w_hit_hi) & (be_i != 4'b0000);

    // Byte-merge into the addressed MTIMECMP half
    assign w_half_old = w_hit_lo ? r_mtimecmp[31:0] : r_mtimecmp[63:32];
    always_comb begin
        w_half_new = w_half_old;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                w_half_new[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end
    assign w_mtc_merged = w_hit_lo ? {r_mtimecmp[63:32], w_half_new}
                                   : {w_half_new, r_mtimecmp[31:0]};

    always_comb begin
        w_rdata = '0;
        if (w_hit_msip) begin
            w_rdata = {31'b0, r_msip};
        end else if (w_hit_lo) begin
            w_rdata = r_mtimecmp[31:0];
        end else if (w_hit_hi) begin
            w_rdata = r_mtimecmp[63:32];
        end else if (w_hit_mtlo) begin
            w_rdata = mtime_i[31:0];
        end else if (w_hit_mthi) begin
            w_rdata = r_snap_v ? r_snap_hi : mtime_i[63:32];
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (req_i) w_state_nxt = c_st_resp;
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        gnt_o = 1'b0;
        case (r_state)
            c_st_idle: gnt_o = req_i;
            default:   gnt_o = 1'b0;
        endcase
    end

    assign w_accept = gnt_o;

    // Registered response, strobes, shadows and MTIME snapshot
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_o         <= 1'b0;
            err_o            <= 1'b0;
            rdata_o          <= '0;
            msip_we_o        <= 1'b0;
            msip_wdata_o     <= 1'b0;
            mtimecmp_we_o    <= 1'b0;
            mtimecmp_wdata_o <= '0;
            r_msip           <= 1'b0;
            r_mtimecmp       <= '0;
            r_snap_hi        <= '0;
            r_snap_v         <= 1'b0;
        end else begin
            rvalid_o      <= w_accept;
            err_o         <= w_accept & w_err;
            rdata_o       <= w_ok_rd ? w_rdata : 32'h0;
            msip_we_o     <= w_msip_wr;
            mtimecmp_we_o <= w_mtc_wr;
            if (w_msip_wr) begin
                msip_wdata_o <= wdata_i[0];
                r_msip       <= wdata_i[0];
            end
            if (w_mtc_wr) begin
                mtimecmp_wdata_o <= w_mtc_merged;
                r_mtimecmp       <= w_mtc_merged;
            end
            if (w_ok_rd && w_hit_mtlo) begin
                r_snap_hi <= mtime_i[63:32];
                r_snap_v  <= 1'b1;
            end else if (w_ok_rd && w_hit_mthi) begin
                r_snap_v  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_regif
// Purpose  : Vector table plus scoreboard bench for clint_regif.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_regif;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [63:0] mtime;
        logic [31:0] rdata;
        logic        err;
        logic        mwe;
        logic        mwd;
        logic        cwe;
        logic [63:0] cwd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mwe;
        logic        mwd;
        logic        cwe;
        logic [63:0] cwd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [63:0] mtime;
    logic        gnt, rvalid, err, msip_we, msip_wd, mtc_we;
    logic [31:0] rdata;
    logic [63:0] mtc_wd;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    clint_regif #(.ADDR_W(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .we_i             (we),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .be_i             (be),
        .gnt_o            (gnt),
        .rvalid_o         (rvalid),
        .rdata_o          (rdata),
        .err_o            (err),
        .msip_we_o        (msip_we),
        .msip_wdata_o     (msip_wd),
        .mtimecmp_we_o    (mtc_we),
        .mtimecmp_wdata_o (mtc_wd),
        .mtime_i          (mtime)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req_v);
        end
    endtask

    // Response monitor: pops the scoreboard on each response pulse
    always @(negedge clk) begin
        exp_t e;
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", 64'(rdata), 64'(e.rdata));
                check("err", 64'(err), 64'(e.err));
                check("msip_we", 64'(msip_we), 64'(e.mwe));
                if (e.mwe) check("msip_wdata", 64'(msip_wd), 64'(e.mwd));
                check("mtimecmp_we", 64'(mtc_we), 64'(e.cwe));
                if (e.cwe) check("mtimecmp_wdata", mtc_wd, e.cwd);
            end
        end else if (rst_n === 1'b1) begin
            check("idle_strobes", {62'd0, msip_we, mtc_we}, 64'd0);
        end
    end

    task automatic run_txn(input vec_t v);
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be; mtime = v.mtime;
        #1;
        check("gnt_idle", 64'(gnt), 64'd1);
        e = '{v.rdata, v.err, v.mwe, v.mwd, v.cwe, v.cwd};
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; mtime = '0;

        //          we    addr      wdata         be    mtime                  rdata         err   mwe   mwd   cwe   cwd
        vecs.push_back('{1'b0, 16'h4000, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h4004, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h0000, 32'h1,        4'hF, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'hF, 64'h0,                 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h4000, 32'hDEADBEEF, 4'hF, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h00000000_DEADBEEF});
        vecs.push_back('{1'b1, 16'h4004, 32'h00000012, 4'h1, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h00000012_DEADBEEF});
        vecs.push_back('{1'b0, 16'h4004, 32'h0,        4'hF, 64'h0,                 32'h12,       1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFF8, 32'h0,        4'hF, 64'h00000001_FFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        4'hF, 64'h00000002_00000005, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        4'hF, 64'h00000002_00000005, 32'h2,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'hBFF8, 32'h55,       4'hF, 64'h0,                 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0002, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h1000, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h4000, 32'h0,        4'hF, 64'h0,                 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'hF, 64'h0,                 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h0000, 32'hFFFFFFFE, 4'hF, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h0000, 32'h1,        4'hE, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'hF, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h4004, 32'hAABBCCDD, 4'h6, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h00BBCC12_DEADBEEF});
        vecs.push_back('{1'b1, 16'h4000, 32'h11111111, 4'h0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h4004, 32'h0,        4'hF, 64'h0,                 32'h00BBCC12, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        4'hF, 64'h00000033_00000000, 32'h33,       1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFF8, 32'h0,        4'hF, 64'h00000005_00000006, 32'h6,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h0000, 32'h1,        4'h1, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        4'hF, 64'h00000007_00000008, 32'h5,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'hBFFC, 32'h9,        4'hF, 64'h0,                 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h0});

        repeat (3) @(negedge clk);
        req = 1'b1;
        #1;
        check("reset_gnt_follows_req", 64'(gnt), 64'd1);
        req = 1'b0;
        #1;
        check("reset_gnt_low", 64'(gnt), 64'd0);
        check("reset_outputs", {rvalid, err, msip_we, mtc_we, msip_wd, rdata}, 37'd0);
        check("reset_mtc_wdata", mtc_wd, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        // Back-to-back requests: grant every other cycle
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h4004; be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("gnt_alternate", 64'(gnt), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0) exp_q.push_back('{32'h00BBCC12, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
            @(negedge clk);
        end
        req = 1'b0;

        // Reset asserted while a write response is pending
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h4000; wdata = 32'h12345678; be = 4'hF;
        exp_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00BBCC12_12345678});
        @(posedge clk);
        #1;
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_resp_rvalid", 64'(rvalid), 64'd0);
        check("rst_in_resp_strobe", 64'(mtc_we), 64'd0);
        req = 1'b1; we = 1'b0; addr = 16'h4000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("gnt_at_release", 64'(gnt), 64'd1);
        exp_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        @(posedge clk);
        #1;
        req = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
